y86_imem_loader: RTL

Y86_IMEM_LOADER -- requirements
Module: y86_imem_loader

---
 rtl/y86_imem_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/y86_imem_loader.sv
// Byte-stream loader for the y86 instruction memory: sync, address, length, data.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module y86_imem_loader #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              cpu_rst_n_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        dbg_state_o
);

  // Handshake: a byte transfers on the rising edge where byte_valid_i && byte_ready_o.
  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_ADDR0 = 3'd1,
    S_ADDR1 = 3'd2,
    S_LEN0  = 3'd3,
    S_LEN1  = 3'd4,
    S_DATA  = 3'd5,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd6,
`endif
    S_DONE  = 3'd7
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(MEM_DEPTH);

  state_t            r_state;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_cpu_rst_n;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_addr;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_accept;
  logic [15:0]       w_len_full;
  logic [16:0]       w_end;
  logic              w_range_err;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_last;

  assign w_accept    = byte_valid_i & r_ready;
  assign w_len_full  = {byte_i, r_len[7:0]};
  // 17-bit sum so a load that runs past 64 KiB cannot wrap into range.
  assign w_end       = {1'b0, r_addr} + {1'b0, w_len_full};
  assign w_range_err = (w_end > LP_DEPTH);
  assign w_wr_addr   = ADDR_W'(r_addr) + ADDR_W'(r_cnt);
  assign w_last      = (r_cnt == (r_len - 16'd1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_SYNC;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_SYNC, S_DONE: begin
            if (byte_i == 8'hA5) begin
              r_state     <= S_ADDR0;
              r_done      <= 1'b0;
              r_err       <= 1'b0;
              r_cpu_rst_n <= 1'b0;
              r_cnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
              r_csum      <= '0;
`endif
            end
          end
          S_ADDR0: begin
            r_addr[7:0] <= byte_i;
            r_state     <= S_ADDR1;
          end
          S_ADDR1: begin
            r_addr[15:8] <= byte_i;
            r_state      <= S_LEN0;
          end
          S_LEN0: begin
            r_len[7:0] <= byte_i;
            r_state    <= S_LEN1;
          end
          S_LEN1: begin
            r_len <= w_len_full;
            r_cnt <= '0;
            if (w_range_err) begin
              r_err   <= 1'b1;
              r_state <= S_SYNC;
            end else if (w_len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= S_CSUM;
`else
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_we       <= 1'b1;
            r_mem_addr <= w_wr_addr;
            r_mem_data <= byte_i;
            r_cnt      <= r_cnt + 16'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ byte_i;
`endif
            if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= S_CSUM;
`else
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
`endif
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (byte_i == r_csum) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_SYNC;
            end
          end
`endif
          default: r_state <= S_SYNC;
        endcase
      end
    end
  end

  assign byte_ready_o = r_ready;
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign cpu_rst_n_o  = r_cpu_rst_n;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign dbg_state_o  = r_state;

endmodule
